// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
// Access size is funct3[1:0]: 00 byte, 01 half, anything else a full word.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TMO_W = 10;

    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   byte_en = 4'b0001 << addr_lo;
            2'b01:   byte_en = 4'b0011 << addr_lo;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~addr_lo[0];
            default: is_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

    // Replicate the store operand across every lane so byte enables alone pick the target.
    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] sd);
        case (funct3[1:0])
            2'b00:   store_wdata = {4{sd[7:0]}};
            2'b01:   store_wdata = {2{sd[15:0]}};
            default: store_wdata = sd;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata, bus_err
    );

endinterface

// File: rtl/load_extender.sv
// Picks the addressed byte/half lane out of a captured word and sign- or zero-extends it.
module load_extender
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {addr_lo_i, 3'b000};

    // NOTE: the default arm assigns data_o on every path, so no latch is inferred.
    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data_o = {24'h000000, shifted[7:0]};
            F3_HU:   data_o = {16'h0000, shifted[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: one bus transaction per memory instruction, stalling the core
// until it retires, with misalignment, bus-error and timeout reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       ReadData,
    output logic              stall,
    output logic              misaligned,
    output logic              access_fault,
    load_store_unit_if.master bus
);

    lsu_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic              load_q;
    logic [31:0]       rdata_q;
    logic              fault_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;

    logic        access;
    logic        aligned;
    logic        start;
    logic [31:0] ext_data;

    assign access     = mem_read | mem_write;
    assign aligned    = is_aligned(funct3, addr[1:0]);
    assign start      = (state_q == IDLE) & access & aligned;
    assign misaligned = (state_q == IDLE) & access & ~aligned;
    assign stall      = start | (state_q == REQ);
    assign tmo_d      = tmo_q + 1'b1;

    load_extender u_ext (
        .word_i    (rdata_q),
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .data_o    (ext_data)
    );

    // A dropped misaligned access must not leak the previous load's value.
    assign ReadData     = misaligned ? 32'h0 : ext_data;
    assign access_fault = fault_q;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    // NOTE: state uses non-blocking assignments under an asynchronous active-low reset,
    // so every register here clears the instant reset falls, even mid-transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            funct3_q  <= 3'h0;
            addr_lo_q <= 2'h0;
            load_q    <= 1'b0;
            rdata_q   <= 32'h0;
            fault_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        req_q     <= 1'b1;
                        we_q      <= mem_write;
                        addr_q    <= {addr[31:2], 2'b00};
                        be_q      <= byte_en(funct3, addr[1:0]);
                        wdata_q   <= store_wdata(funct3, store_data);
                        funct3_q  <= funct3;
                        addr_lo_q <= addr[1:0];
                        load_q    <= mem_read & ~mem_write;
                        rdata_q   <= 32'h0;
                        tmo_q     <= '0;
                    end else if (misaligned) begin
                        rdata_q <= 32'h0;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        rdata_q <= (load_q && !bus.bus_err) ? bus.bus_rdata : 32'h0;
                        fault_q <= bus.bus_err;
                        tmo_q   <= '0;
                    end else if (tmo_d == TMO_W'(TIMEOUT)) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        rdata_q <= 32'h0;
                        fault_q <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// compared against a byte-lane reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] ReadData;
    logic        stall;
    logic        misaligned;
    logic        access_fault;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .ReadData     (ReadData),
        .stall        (stall),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference load result: shift the addressed lane down, mask to size, extend arithmetically.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int nb;
        logic [31:0] v;
        nb = size_bytes(f3);
        v  = word >> (8 * int'(a[1:0]));
        if (nb == 1) begin
            v = v & 32'hFF;
            if (f3[2] == 1'b0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (f3[2] == 1'b0 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input int wait_n,
                             input bit err, input bit noack, input logic [31:0] rdata,
                             input string tag);
        int          nb;
        int          bm;
        bit          exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        bit          exp_fault;
        int          exp_stall;
        int          exp_req;
        int          stalls;
        int          reqs;
        bit          done;
        nb      = size_bytes(f3);
        exp_mis = (int'(a[1:0]) % nb) != 0;
        bm      = ((1 << nb) - 1) << int'(a[1:0]);
        exp_be  = bm[3:0];
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sd[8*(i % nb) +: 8];
        exp_fault = noack | err;
        exp_rd    = (wr || exp_fault) ? 32'h0 : model_load(f3, a, rdata);
        exp_stall = noack ? TMO + 1 : wait_n + 2;
        exp_req   = noack ? TMO : wait_n + 1;

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        n_cmp++;
        if (misaligned !== exp_mis) begin
            n_bad++;
            $display("FAIL %s misaligned: got %b want %b", tag, misaligned, exp_mis);
        end
        if (exp_mis) begin
            n_cmp++;
            if ({stall, bus.bus_req, ReadData} !== 34'h0) begin
                n_bad++;
                $display("FAIL %s misaligned_quiet: stall=%b req=%b rdata=%h want all 0",
                         tag, stall, bus.bus_req, ReadData);
            end
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            n_cmp++;
            if (bus.bus_req !== 1'b0) begin
                n_bad++;
                $display("FAIL %s misaligned_no_req: got %b want 0", tag, bus.bus_req);
            end
            return;
        end

        stalls = 0; reqs = 0; done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (stall === 1'b1) stalls++;
            if (bus.bus_req === 1'b1) begin
                reqs++;
                n_cmp++;
                if ({bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata} !==
                    {wr, a & 32'hFFFF_FFFC, exp_be, exp_wd}) begin
                    n_bad++;
                    $display("FAIL %s bus_fields: got we=%b a=%h be=%b wd=%h want we=%b a=%h be=%b wd=%h",
                             tag, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata,
                             wr, a & 32'hFFFF_FFFC, exp_be, exp_wd);
                end
                if (!noack && reqs == wait_n + 1) begin
                    bus.bus_ack = 1'b1; bus.bus_rdata = rdata; bus.bus_err = err;
                end
            end else if (cyc > 0 && stall === 1'b0) begin
                done = 1'b1;
                n_cmp++;
                if (ReadData !== exp_rd) begin
                    n_bad++;
                    $display("FAIL %s ReadData: got %h want %h", tag, ReadData, exp_rd);
                end
                n_cmp++;
                if (access_fault !== exp_fault) begin
                    n_bad++;
                    $display("FAIL %s access_fault: got %b want %b", tag, access_fault, exp_fault);
                end
                mem_read = 1'b0; mem_write = 1'b0;
            end
            @(posedge clk); #1;
            bus.bus_ack = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = $urandom;
            #1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s completion: got no DONE cycle want DONE within 64 cycles", tag);
            mem_read = 1'b0; mem_write = 1'b0;
        end
        n_cmp++;
        if (stalls !== exp_stall) begin
            n_bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_stall);
        end
        n_cmp++;
        if (reqs !== exp_req) begin
            n_bad++;
            $display("FAIL %s req_cycles: got %0d want %0d", tag, reqs, exp_req);
        end
        n_cmp++;
        if ({access_fault, bus.bus_req, stall} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s after_done: fault=%b req=%b stall=%b want 0 0 0",
                     tag, access_fault, bus.bus_req, stall);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata} !== 70'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got req=%b we=%b a=%h be=%b wd=%h want all 0",
                     bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata);
        end
        n_cmp++;
        if ({ReadData, stall, misaligned, access_fault} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_core: got rd=%h stall=%b mis=%b fault=%b want all 0",
                     ReadData, stall, misaligned, access_fault);
        end
        reset = 1'b1;
    endtask

    task automatic test_store_word();
        do_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0, "sw_zero_wait");
    endtask

    task automatic test_load_extend();
        do_access(1'b1, 1'b0, F3_B,  32'h103, 32'h0, 0, 1'b0, 1'b0, 32'h80FF_FF7F, "lb_sign");
        do_access(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 1, 1'b0, 1'b0, 32'h80FF_FF7F, "lbu_zero");
        do_access(1'b1, 1'b0, F3_H,  32'h102, 32'h0, 0, 1'b0, 1'b0, 32'h9abc_1234, "lh_sign");
        do_access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 0, 1'b0, 1'b0, 32'h9abc_1234, "lhu_zero");
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 1'b0, F3_H, 32'h101, 32'h0, 0, 1'b0, 1'b0, 32'h0, "lh_misaligned");
        do_access(1'b0, 1'b1, F3_W, 32'h106, 32'h5, 0, 1'b0, 1'b0, 32'h0, "sw_misaligned");
    endtask

    task automatic test_store_half();
        do_access(1'b0, 1'b1, F3_H, 32'h102, 32'h1234ABCD, 0, 1'b0, 1'b0, 32'h0, "sh_upper");
        do_access(1'b0, 1'b1, F3_B, 32'h101, 32'h1234ABCD, 2, 1'b0, 1'b0, 32'h0, "sb_lane1");
    endtask

    task automatic test_wait_states();
        do_access(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 3, 1'b0, 1'b0, 32'hCAFE_F00D, "lw_3wait");
        do_access(1'b1, 1'b1, F3_W, 32'h204, 32'h0BAD_0BAD, 1, 1'b0, 1'b0, 32'hFFFF_FFFF, "rw_as_store");
    endtask

    task automatic test_faults();
        do_access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 0, 1'b0, 1'b1, 32'h1111_2222, "lw_timeout");
        do_access(1'b1, 1'b0, F3_W, 32'h304, 32'h0, 2, 1'b1, 1'b0, 32'h3333_4444, "lw_bus_err");
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h400;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.bus_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_req_entered: got req=%b want 1", bus.bus_req);
        end
        reset = 1'b0; mem_read = 1'b0;
        #1;
        n_cmp++;
        if ({bus.bus_req, bus.bus_be, stall, ReadData} !== 38'h0) begin
            n_bad++;
            $display("FAIL rst_mid_req_clear: got req=%b be=%b stall=%b rd=%h want all 0",
                     bus.bus_req, bus.bus_be, stall, ReadData);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        #1;
        n_cmp++;
        if ({bus.bus_req, stall, access_fault, ReadData} !== 35'h0) begin
            n_bad++;
            $display("FAIL rst_stale_ack: got req=%b stall=%b fault=%b rd=%h want all 0",
                     bus.bus_req, stall, access_fault, ReadData);
        end
        do_access(1'b1, 1'b0, F3_W, 32'h404, 32'h0, 1, 1'b0, 1'b0, 32'h1357_9BDF, "lw_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit          rd;
            bit          wr;
            int          mode;
            logic [2:0]  f3;
            logic [31:0] a;
            rd   = 1'($urandom_range(0, 1));
            wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            mode = $urandom_range(0, 7);
            do_access(rd, wr, f3, a, $urandom, $urandom_range(0, 2), mode == 1, mode == 0,
                      $urandom, "random");
        end
    endtask

    initial begin
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'h0; addr = 32'h0; store_data = 32'h0;
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0; bus.bus_err = 1'b0;
        test_reset();
        test_store_word();
        test_load_extend();
        test_misaligned();
        test_store_half();
        test_wait_states();
        test_faults();
        test_reset_mid_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
